// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and helpers for the iterative RV32M multiply/divide unit.
//   XLEN       operand/result width
//   OP_*       funct3 encodings of the eight M-extension operations
//   state_t    control FSM encoding (ST_IDLE, ST_CALC, ST_DONE)
//   MODE_*     datapath step mode (shift-add multiply or restoring divide)
//   DIV0_Q     quotient produced by a divide by zero
//   cond_neg*  two's-complement negate when a flag is set
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    localparam logic [XLEN-1:0] DIV0_Q = {XLEN{1'b1}};

    // Negate a single-width value when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Negate a double-width product when neg is set.
    function automatic logic [2*XLEN-1:0] cond_neg64(input logic [2*XLEN-1:0] v, input logic neg);
        logic [2*XLEN-1:0] r;
        if (neg) begin
            r = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_iter_dp.sv
// mdu_iter_dp: shared shift / add-subtract datapath, one step per cycle.
//   load   capture magnitudes: hi <= 0, lo <= a_mag, divisor/multiplicand <= b_mag
//   step   advance one iteration in the selected mode
//   mode   MODE_MUL: {hi,lo} is the 64-bit product, lo doubles as the multiplier
//          MODE_DIV: hi is the partial remainder, lo shifts dividend out and quotient in
//   hi_nx/lo_nx  value hi/lo will take after the current step (lets the top register
//          the final result on the same edge as the last step)
module mdu_iter_dp #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            mode,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi_nx,
    output logic [XLEN-1:0] lo_nx
);
    import mdu_pkg::*;

    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN:0]   x_s;
    logic [XLEN:0]   y_s;
    logic [XLEN:0]   sum_s;

    // One iteration of shift-add multiply or restoring divide through a single adder.
    always_comb begin
        y_s   = {1'b0, b_r};
        x_s   = {(XLEN+1){1'b0}};
        sum_s = {(XLEN+1){1'b0}};
        hi_nx = hi_r;
        lo_nx = lo_r;
        if (mode == MODE_DIV) begin
            // Remainder stays below the divisor, so the shifted value fits in XLEN+1
            // bits and bit XLEN of the difference is a reliable borrow.
            x_s   = {hi_r, lo_r[XLEN-1]};
            sum_s = x_s - y_s;
            if (sum_s[XLEN]) begin
                hi_nx = x_s[XLEN-1:0];
                lo_nx = {lo_r[XLEN-2:0], 1'b0};
            end else begin
                hi_nx = sum_s[XLEN-1:0];
                lo_nx = {lo_r[XLEN-2:0], 1'b1};
            end
        end else begin
            x_s = {1'b0, hi_r};
            if (lo_r[0]) begin
                sum_s = x_s + y_s;
            end else begin
                sum_s = x_s;
            end
            // Shift {carry, sum, multiplier} right by one.
            hi_nx = sum_s[XLEN:1];
            lo_nx = {sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Working registers: load on accept, advance on each step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= {XLEN{1'b0}};
            lo_r <= {XLEN{1'b0}};
            b_r  <= {XLEN{1'b0}};
        end else if (load) begin
            hi_r <= {XLEN{1'b0}};
            lo_r <= a_mag;
            b_r  <= b_mag;
        end else if (step) begin
            hi_r <= hi_nx;
            lo_r <= lo_nx;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, fixed 33-cycle latency.
//   clk, reset (async, active-high)
//   start, op[2:0], a, b, rd_in : request, sampled only in IDLE
//   busy   : high from the cycle after accept through the DONE cycle
//   done   : one-cycle pulse with result/rd_out valid
//   result, rd_out : to register-file write port, held until the next accept
//   we     : done and rd_out != 0
module mdu_iter #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we
);
    import mdu_pkg::*;

    state_t          state_r;
    state_t          state_nx_s;
    logic [5:0]      cnt_r;
    logic            accept_s;
    logic            step_s;
    logic            last_s;

    logic [2:0]      op_r;
    logic [4:0]      rd_r;
    logic            a_neg_r;
    logic            b_neg_r;
    logic            b_zero_r;

    logic            a_signed_s;
    logic            b_signed_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;

    logic [XLEN-1:0]   hi_nx_s;
    logic [XLEN-1:0]   lo_nx_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   res_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and per-cycle controls; start outside IDLE is simply not looked at.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        step_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                step_s = 1'b1;
                if (cnt_r == 6'(ITER - 1)) begin
                    last_s     = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Iteration counter, runs only while calculating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 6'd0;
        end else if (step_s && !last_s) begin
            cnt_r <= cnt_r + 6'd1;
        end else begin
            cnt_r <= 6'd0;
        end
    end

    // Operand signedness and magnitudes for the incoming request.
    always_comb begin
        a_signed_s = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                     (op == OP_DIV) || (op == OP_REM);
        b_signed_s = (op == OP_MUL) || (op == OP_MULH) ||
                     (op == OP_DIV) || (op == OP_REM);
        a_neg_s    = a_signed_s && a[XLEN-1];
        b_neg_s    = b_signed_s && b[XLEN-1];
        // |0x80000000| wraps back to 0x80000000, which is correct read as unsigned.
        a_mag_s    = cond_neg(a, a_neg_s);
        b_mag_s    = cond_neg(b, b_neg_s);
    end

    // Request latch: op, destination and sign flags captured at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= OP_MUL;
            rd_r     <= 5'd0;
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            b_zero_r <= 1'b0;
        end else if (accept_s) begin
            op_r     <= op;
            rd_r     <= rd_in;
            a_neg_r  <= a_neg_s;
            b_neg_r  <= b_neg_s;
            b_zero_r <= (b == {XLEN{1'b0}});
        end
    end

    mdu_iter_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk   (clk),
        .reset (reset),
        .load  (accept_s),
        .step  (step_s),
        .mode  (op_r[2] ? MODE_DIV : MODE_MUL),
        .a_mag (a_mag_s),
        .b_mag (b_mag_s),
        .hi_nx (hi_nx_s),
        .lo_nx (lo_nx_s)
    );

    // Sign correction of the final step's output and op selection.
    always_comb begin
        prod_s = cond_neg64({hi_nx_s, lo_nx_s}, a_neg_r ^ b_neg_r);
        // Divide by zero leaves an all-ones quotient (DIV0_Q); keep it unsigned.
        quo_s  = cond_neg(lo_nx_s, (a_neg_r ^ b_neg_r) && !b_zero_r);
        rem_s  = cond_neg(hi_nx_s, a_neg_r);
        case (op_r)
            OP_MUL:                       res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res_s = quo_s;
            OP_REM, OP_REMU:              res_s = rem_s;
            default:                      res_s = {XLEN{1'b0}};
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            we     <= 1'b0;
            result <= {XLEN{1'b0}};
            rd_out <= 5'd0;
        end else begin
            done <= last_s;
            we   <= last_s && (rd_r != 5'd0);
            if (accept_s) begin
                busy <= 1'b1;
            end else if (state_r == ST_DONE) begin
                busy <= 1'b0;
            end
            if (last_s) begin
                result <= res_s;
                rd_out <= rd_r;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we     (we)
    );

    always #5 clk = ~clk;

    // Issue one op from IDLE, scramble inputs after accept, wait (bounded) for done.
    // lat = cycle index of done relative to the accept edge; busy_cnt = busy cycles seen.
    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] r, output logic [31:0] res, output logic [4:0] rdo,
                         output logic weo, output int lat, output int busy_cnt);
        op = o; a = av; b = bv; rd_in = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom); rd_in = 5'($urandom);
        lat = 1; busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_cnt++;
        res = result; rdo = rd_out; weo = we;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", result); end
        n_checks++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy %b want 0", busy); end
    endtask

    task automatic test_mul;
        logic [31:0] res; logic [4:0] rdo; logic weo; int lat, bc;
        do_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, res, rdo, weo, lat, bc);
        n_checks++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_res: got %h want FFFFFFEB", res); end
        n_checks++; if (rdo !== 5'd5) begin n_fail++; $display("FAIL mul_rd: got %0d want 5", rdo); end
        n_checks++; if (weo !== 1'b1) begin n_fail++; $display("FAIL mul_we: got %b want 1", weo); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
        n_checks++; if (bc != 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mul_after: busy %b done %b want 0 0", busy, done); end
    endtask

    task automatic test_mulh;
        logic [2:0] ops [3]; logic [31:0] exp [3];
        logic [31:0] res; logic [4:0] rdo; logic weo; int lat, bc;
        ops[0] = OP_MULH;   exp[0] = 32'h00000000;
        ops[1] = OP_MULHSU; exp[1] = 32'h80000000;
        ops[2] = OP_MULHU;  exp[2] = 32'h7FFFFFFF;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], 32'h80000000, 32'hFFFFFFFF, 5'd10, res, rdo, weo, lat, bc);
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL mulh_res[%0d]: got %h want %h", i, res, exp[i]); end
            n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mulh_latency[%0d]: got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_div_corner;
        logic [2:0] ops [10]; logic [31:0] av [10]; logic [31:0] bv [10]; logic [31:0] exp [10];
        logic [31:0] res; logic [4:0] rdo; logic weo; int lat, bc;
        ops[0] = OP_DIV;  av[0] = 32'hFFFFFFF9; bv[0] = 32'd2;         exp[0] = 32'hFFFFFFFD;
        ops[1] = OP_REM;  av[1] = 32'hFFFFFFF9; bv[1] = 32'd2;         exp[1] = 32'hFFFFFFFF;
        ops[2] = OP_DIVU; av[2] = 32'd7;        bv[2] = 32'd2;         exp[2] = 32'd3;
        ops[3] = OP_REMU; av[3] = 32'd7;        bv[3] = 32'd2;         exp[3] = 32'd1;
        ops[4] = OP_DIV;  av[4] = 32'd5;        bv[4] = 32'd0;         exp[4] = 32'hFFFFFFFF;
        ops[5] = OP_REM;  av[5] = 32'd5;        bv[5] = 32'd0;         exp[5] = 32'd5;
        ops[6] = OP_DIVU; av[6] = 32'd5;        bv[6] = 32'd0;         exp[6] = 32'hFFFFFFFF;
        ops[7] = OP_DIV;  av[7] = 32'h80000000; bv[7] = 32'hFFFFFFFF;  exp[7] = 32'h80000000;
        ops[8] = OP_REM;  av[8] = 32'h80000000; bv[8] = 32'hFFFFFFFF;  exp[8] = 32'd0;
        ops[9] = OP_DIV;  av[9] = 32'hFFFFFFFB; bv[9] = 32'd0;         exp[9] = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            do_op(ops[i], av[i], bv[i], 5'd17, res, rdo, weo, lat, bc);
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL div_res[%0d]: got %h want %h", i, res, exp[i]); end
            n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
            n_checks++; if (weo !== 1'b1) begin n_fail++; $display("FAIL div_we[%0d]: got %b want 1", i, weo); end
        end
    endtask

    task automatic test_rd_zero;
        logic [31:0] res; logic [4:0] rdo; logic weo; int lat, bc;
        do_op(OP_MUL, 32'd6, 32'd7, 5'd0, res, rdo, weo, lat, bc);
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rd0_done_latency: got %0d want 33", lat); end
        n_checks++; if (weo !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got %b want 0", weo); end
        n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL rd0_res: got %h want 0000002a", res); end
    endtask

    task automatic test_start_ignored;
        int n_done = 0; int done_cyc = 0; logic [31:0] res = 32'd0;
        op = OP_DIVU; a = 32'd100; b = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 70; c++) begin
            start = (c == 5 || c == 20 || c == 33);
            a = $urandom; b = $urandom;
            if (done) begin n_done++; done_cyc = c; res = result; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
        n_checks++; if (done_cyc != 33) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 33", done_cyc); end
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL ignore_res: got %h want 0000000e", res); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int cnt;
        op = OP_MUL; a = 32'h10; b = 32'd3; rd_in = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        cnt = 1;
        while (!done && cnt < 60) begin @(posedge clk); #1; cnt++; end
        n_checks++; if (cnt != 33) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 33", cnt); end
        n_checks++; if (result !== 32'h30) begin n_fail++; $display("FAIL b2b_first_res: got %h want 00000030", result); end
        a = 32'd9;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy %b want 0 at T+34", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: busy %b want 1 at T+35", busy); end
        cnt = 1;
        while (!done && cnt < 60) begin @(posedge clk); #1; cnt++; end
        n_checks++; if (cnt != 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 33", cnt); end
        n_checks++; if (result !== 32'h1B) begin n_fail++; $display("FAIL b2b_second_res: got %h want 0000001b", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int n_done = 0;
        logic [31:0] res; logic [4:0] rdo; logic weo; int lat, bc;
        op = OP_MUL; a = 32'd3; b = 32'd5; rd_in = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL midrst_done_we: got %b %b want 0 0", done, we); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL midrst_result: got %h want 00000000", result); end
        n_checks++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL midrst_rd: got %0d want 0", rd_out); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || we) n_done++;
            @(posedge clk); #1;
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", n_done); end
        do_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, res, rdo, weo, lat, bc);
        n_checks++; if (res !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL midrst_after_res: got %h want FFFFFFFE", res); end
        n_checks++; if (lat != 33 || weo !== 1'b1 || rdo !== 5'd31) begin
            n_fail++; $display("FAIL midrst_after_ctl: lat %0d we %b rd %0d want 33 1 31", lat, weo, rdo);
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_mulh;
        test_div_corner;
        test_rd_zero;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
